// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix datapath blocks (multiplier, serializer, loaders).
package matrix_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Bit offset of element (i,j) on the flat row-major matrix bus.
    function automatic int word_lsb(input int i, input int j, input int n);
        return (i * n + j) * WORD_W;
    endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row/column walker over an N x N matrix in row-major order.
module matrix_index_counter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             last
);

    logic [IDX_W-1:0] r_row;
    logic [IDX_W-1:0] r_col;

    // Step the column, wrapping into the next row; clear restarts at (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (advance) begin
            if (r_col == IDX_W'(N - 1)) begin
                r_col <= '0;
                r_row <= r_row + IDX_W'(1);
            end else begin
                r_col <= r_col + IDX_W'(1);
            end
        end
    end

    assign row  = r_row;
    assign col  = r_col;
    assign last = (r_row == IDX_W'(N - 1)) && (r_col == IDX_W'(N - 1));

endmodule

// File: rtl/matrix_serializer.sv
// Captures one flat row-major matrix and streams it out one word per beat.
module matrix_serializer
    import matrix_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORD_W*N*N:0]     mat_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_W-1:0]       out_data,
    output logic [IDX_W-1:0]        out_row,
    output logic [IDX_W-1:0]        out_col,
    output logic                    out_last
);

    state_t                  r_state;
    state_t                  w_nextState;
    logic [WORD_W*N*N-1:0]   r_mat;
    logic [IDX_W-1:0]        w_row;
    logic [IDX_W-1:0]        w_col;
    logic                    w_last;
    logic                    w_accept;
    logic                    w_capture;
    logic                    w_clear;
    logic                    w_advance;
    logic [WORD_W-1:0]       w_word;
    logic                    w_unused;

    // The top bit of the bus carries nothing for this block.
    assign w_unused = mat_in[WORD_W*N*N];

    assign w_accept  = out_valid && out_ready;
    assign w_capture = in_valid && in_ready;
    assign w_clear   = w_capture || (w_accept && w_last);
    assign w_advance = w_accept && !w_last;

    matrix_index_counter #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_index (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_clear),
        .advance (w_advance),
        .row     (w_row),
        .col     (w_col),
        .last    (w_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and handshake; ready reopens on the accepted final beat so matrices chain without a bubble.
    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_nextState = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready && w_last) begin
                    in_ready = 1'b1;
                    if (!in_valid) begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Local copy of the matrix so upstream may move on right after capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mat <= '0;
        end else if (w_capture) begin
            r_mat <= mat_in[WORD_W*N*N-1:0];
        end
    end

    // Pick the element addressed by the row/column counters with constant-offset selects.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (w_row == IDX_W'(i) && w_col == IDX_W'(j)) begin
                    w_word = r_mat[word_lsb(i, j, N) +: WORD_W];
                end
            end
        end
    end

    // Output payload, forced to zero whenever nothing is being offered.
    always_comb begin
        out_data = '0;
        out_row  = '0;
        out_col  = '0;
        out_last = 1'b0;
        if (r_state == SEND) begin
            out_data = w_word;
            out_row  = w_row;
            out_col  = w_col;
            out_last = w_last;
        end
    end

endmodule

// File: tb/tb_matrix_serializer.sv
// Directed bench for matrix_serializer at N=2, N=3 and N=1.
module tb_matrix_serializer;

    logic clk;
    logic rst_n;

    // N=2 instance signals
    logic         iv2, ir2, ov2, or2, olast2;
    logic [128:0] mat2;
    logic [31:0]  od2;
    logic [0:0]   orow2, ocol2;

    // N=3 instance signals
    logic         iv3, ir3, ov3, or3, olast3;
    logic [288:0] mat3;
    logic [31:0]  od3;
    logic [1:0]   orow3, ocol3;

    // N=1 instance signals
    logic         iv1, ir1, ov1, or1, olast1;
    logic [32:0]  mat1;
    logic [31:0]  od1;
    logic [0:0]   orow1, ocol1;

    int totalChecks = 0;
    int badChecks   = 0;

    typedef struct {
        logic        inValid;
        logic        outReady;
        int          matBase;
        logic        topBit;
        logic        expValid;
        logic [31:0] expData;
        logic        expRow;
        logic        expCol;
        logic        expLast;
        logic        expInReady;
    } vec_t;

    vec_t vecs[$];

    matrix_serializer #(.N(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .mat_in(mat2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_row(orow2),
        .out_col(ocol2), .out_last(olast2)
    );

    matrix_serializer #(.N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .mat_in(mat3),
        .out_valid(ov3), .out_ready(or3), .out_data(od3), .out_row(orow3),
        .out_col(ocol3), .out_last(olast3)
    );

    matrix_serializer #(.N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .mat_in(mat1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_row(orow1),
        .out_col(ocol1), .out_last(olast1)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [128:0] buildMat2(input int base, input logic top);
        logic [128:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) m[k*32 +: 32] = 32'(base + k);
        m[128] = top;
        return m;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic iv, input logic ordy, input int base, input logic top,
                          input logic ev, input int ed, input logic er, input logic ec,
                          input logic el, input logic eir);
        vec_t v;
        v.inValid = iv; v.outReady = ordy; v.matBase = base; v.topBit = top;
        v.expValid = ev; v.expData = 32'(ed); v.expRow = er; v.expCol = ec;
        v.expLast = el; v.expInReady = eir;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        iv2  = v.inValid;
        or2  = v.outReady;
        mat2 = buildMat2(v.matBase, v.topBit);
        #1;
        checkOutput($sformatf("vec%0d.valid", idx), 32'(ov2), 32'(v.expValid));
        checkOutput($sformatf("vec%0d.data", idx), od2, v.expData);
        checkOutput($sformatf("vec%0d.row", idx), 32'(orow2), 32'(v.expRow));
        checkOutput($sformatf("vec%0d.col", idx), 32'(ocol2), 32'(v.expCol));
        checkOutput($sformatf("vec%0d.last", idx), 32'(olast2), 32'(v.expLast));
        checkOutput($sformatf("vec%0d.in_ready", idx), 32'(ir2), 32'(v.expInReady));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        iv2 = 0; or2 = 0; mat2 = '0;
        iv3 = 0; or3 = 0; mat3 = '0;
        iv1 = 0; or1 = 0; mat1 = '0;

        // Vector table: inValid outReady matBase topBit | valid data row col last in_ready
        // Basic stream with bus changed (and bit 128 set) right after capture.
        addVec(1, 1,  1, 0,  0, 0, 0, 0, 0, 1);
        addVec(0, 1, 20, 1,  1, 1, 0, 0, 0, 0);
        addVec(0, 1, 20, 1,  1, 2, 0, 1, 0, 0);
        addVec(0, 1, 20, 1,  1, 3, 1, 0, 0, 0);
        addVec(0, 1, 20, 1,  1, 4, 1, 1, 1, 1);
        addVec(0, 1, 20, 1,  0, 0, 0, 0, 0, 1);
        // Backpressure: out_ready 1,0,0,1,1,0,1.
        addVec(1, 0,  1, 0,  0, 0, 0, 0, 0, 1);
        addVec(0, 1,  1, 0,  1, 1, 0, 0, 0, 0);
        addVec(0, 0,  1, 0,  1, 2, 0, 1, 0, 0);
        addVec(0, 0,  1, 0,  1, 2, 0, 1, 0, 0);
        addVec(0, 1,  1, 0,  1, 2, 0, 1, 0, 0);
        addVec(0, 1,  1, 0,  1, 3, 1, 0, 0, 0);
        addVec(0, 0,  1, 0,  1, 4, 1, 1, 1, 0);
        addVec(0, 1,  1, 0,  1, 4, 1, 1, 1, 1);
        addVec(0, 1,  1, 0,  0, 0, 0, 0, 0, 1);
        // Back-to-back: in_valid held high, 5..8 follows 4 without a gap.
        addVec(1, 1,  1, 0,  0, 0, 0, 0, 0, 1);
        addVec(1, 1,  5, 0,  1, 1, 0, 0, 0, 0);
        addVec(1, 1,  5, 0,  1, 2, 0, 1, 0, 0);
        addVec(1, 1,  5, 0,  1, 3, 1, 0, 0, 0);
        addVec(1, 1,  5, 0,  1, 4, 1, 1, 1, 1);
        addVec(0, 1,  5, 0,  1, 5, 0, 0, 0, 0);
        addVec(0, 1,  5, 0,  1, 6, 0, 1, 0, 0);
        addVec(0, 1,  5, 0,  1, 7, 1, 0, 0, 0);
        addVec(0, 1,  5, 0,  1, 8, 1, 1, 1, 1);
        addVec(0, 1,  5, 0,  0, 0, 0, 0, 0, 1);

        // Reset state, checked while rst_n is still low.
        #2;
        checkOutput("reset.in_ready", 32'(ir2), 32'd1);
        checkOutput("reset.out_valid", 32'(ov2), 32'd0);
        checkOutput("reset.out_data", od2, 32'd0);
        checkOutput("reset.out_last", 32'(olast2), 32'd0);
        nextCycle();
        rst_n = 1'b1;
        nextCycle();

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

        // Asynchronous reset after two accepted beats.
        iv2 = 1; or2 = 1; mat2 = buildMat2(1, 0);
        nextCycle();
        iv2 = 0;
        nextCycle();
        nextCycle();
        #1;
        checkOutput("rst.pre_data", od2, 32'd3);
        rst_n = 1'b0;
        #1;
        checkOutput("rst.async_valid", 32'(ov2), 32'd0);
        checkOutput("rst.async_in_ready", 32'(ir2), 32'd1);
        checkOutput("rst.async_data", od2, 32'd0);
        nextCycle();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput($sformatf("rst.idle%0d_valid", c), 32'(ov2), 32'd0);
            checkOutput($sformatf("rst.idle%0d_in_ready", c), 32'(ir2), 32'd1);
            nextCycle();
        end
        iv2 = 1; mat2 = buildMat2(9, 0);
        nextCycle();
        iv2 = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput($sformatf("rst.new%0d_valid", k), 32'(ov2), 32'd1);
            checkOutput($sformatf("rst.new%0d_data", k), od2, 32'(9 + k));
            checkOutput($sformatf("rst.new%0d_row", k), 32'(orow2), 32'(k / 2));
            checkOutput($sformatf("rst.new%0d_col", k), 32'(ocol2), 32'(k % 2));
            nextCycle();
        end
        #1;
        checkOutput("rst.done_valid", 32'(ov2), 32'd0);

        // N=3: nine beats, words 10..18.
        for (int k = 0; k < 9; k++) mat3[k*32 +: 32] = 32'(10 + k);
        iv3 = 1; or3 = 1;
        nextCycle();
        iv3 = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                #1;
                checkOutput($sformatf("n3.%0d%0d_valid", i, j), 32'(ov3), 32'd1);
                checkOutput($sformatf("n3.%0d%0d_data", i, j), od3, 32'(10 + i*3 + j));
                checkOutput($sformatf("n3.%0d%0d_row", i, j), 32'(orow3), 32'(i));
                checkOutput($sformatf("n3.%0d%0d_col", i, j), 32'(ocol3), 32'(j));
                checkOutput($sformatf("n3.%0d%0d_last", i, j), 32'(olast3), (i == 2 && j == 2) ? 32'd1 : 32'd0);
                nextCycle();
            end
        end
        #1;
        checkOutput("n3.idle_valid", 32'(ov3), 32'd0);
        checkOutput("n3.idle_in_ready", 32'(ir3), 32'd1);

        // N=1: a single beat carrying out_last.
        mat1 = {1'b1, 32'hDEADBEEF};
        iv1 = 1; or1 = 1;
        #1;
        checkOutput("n1.idle_in_ready", 32'(ir1), 32'd1);
        nextCycle();
        iv1 = 0;
        #1;
        checkOutput("n1.valid", 32'(ov1), 32'd1);
        checkOutput("n1.data", od1, 32'hDEADBEEF);
        checkOutput("n1.last", 32'(olast1), 32'd1);
        checkOutput("n1.row", 32'(orow1), 32'd0);
        checkOutput("n1.in_ready", 32'(ir1), 32'd1);
        nextCycle();
        #1;
        checkOutput("n1.after_valid", 32'(ov1), 32'd0);
        checkOutput("n1.after_data", od1, 32'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
